// File: rtl/rf_pkg.sv
// rf_pkg: shared constants, index-width helper and read-source selection for reg_file_mp
package rf_pkg;
  localparam int RF_ZERO = 0;
  typedef enum logic [1:0] {SEL_ZERO, SEL_REG, SEL_WR0, SEL_WR1} rd_sel_e;
  function automatic int rf_idx_w(int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  // wr1 outranks wr0 so a bypassed read matches the value that will be stored
  function automatic rd_sel_e rd_sel(logic en, logic byp, logic zero, logic hit0, logic hit1);
    return (!en || zero) ? SEL_ZERO : (byp && hit1) ? SEL_WR1 : (byp && hit0) ? SEL_WR0 : SEL_REG;
  endfunction
endpackage

// File: rtl/reg_file_mp_cell.sv
// rf_cell: WIDTH-bit storage register with synchronous reset and write enable
module rf_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q, q_d;
  always_comb q_d = rst ? '0 : en ? d : q_q;
  always_ff @(posedge clk) q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: 2-read/2-write register file with write bypass, optional registered reads and busy scoreboard
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  localparam int IDX_W   = rf_idx_w(DEPTH),
  parameter int READ_LAT = 0,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdA_en,
  input  logic [IDX_W-1:0] rdA_idx,
  output logic [WIDTH-1:0] rdA_dat,
  output logic             rdA_busy,
  input  logic             rdB_en,
  input  logic [IDX_W-1:0] rdB_idx,
  output logic [WIDTH-1:0] rdB_dat,
  output logic             rdB_busy,
  input  logic             wr0_en,
  input  logic [IDX_W-1:0] wr0_idx,
  input  logic [WIDTH-1:0] wr0_dat,
  input  logic             wr1_en,
  input  logic [IDX_W-1:0] wr1_idx,
  input  logic [WIDTH-1:0] wr1_dat,
  input  logic             bs_en,
  input  logic [IDX_W-1:0] bs_idx,
  output logic [DEPTH-1:0] busy_vec
);
  localparam logic BYP = BYPASS != 0;
  localparam logic ZR  = ZERO_R0 != 0;
  logic [WIDTH-1:0]      regs [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d, we;
  logic [1:0]            rd_en, rb_d, rb_o;
  logic [IDX_W-1:0]      rd_idx [2];
  logic [1:0][WIDTH-1:0] rd_d, rd_o;
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic hit0, hit1;
    assign hit0  = wr0_en && wr0_idx == IDX_W'(i);
    assign hit1  = wr1_en && wr1_idx == IDX_W'(i);
    assign we[i] = (hit0 || hit1) && !(ZR && i == RF_ZERO);
    rf_cell #(.WIDTH(WIDTH)) u_cell (
      .clk(clk), .rst(rst), .en(we[i]), .d(hit1 ? wr1_dat : wr0_dat), .q(regs[i])
    );
  end
  // a busy-set in the same cycle as the clearing write wins: a new producer is outstanding
  always_comb begin
    busy_d = busy_q & ~we;
    if (bs_en && !(ZR && bs_idx == IDX_W'(RF_ZERO))) busy_d[bs_idx] = 1'b1;
  end
  always_ff @(posedge clk) busy_q <= rst ? '0 : busy_d;
  assign busy_vec  = busy_q;
  assign rd_en     = {rdB_en, rdA_en};
  assign rd_idx[0] = rdA_idx;
  assign rd_idx[1] = rdB_idx;
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic    hit0, hit1;
    rd_sel_e sel;
    always_comb begin
      hit0    = wr0_en && wr0_idx == rd_idx[p];
      hit1    = wr1_en && wr1_idx == rd_idx[p];
      sel     = rd_sel(rd_en[p], BYP, ZR && rd_idx[p] == IDX_W'(RF_ZERO), hit0, hit1);
      rd_d[p] = sel == SEL_WR1 ? wr1_dat : sel == SEL_WR0 ? wr0_dat : sel == SEL_REG ? regs[rd_idx[p]] : '0;
      rb_d[p] = busy_q[rd_idx[p]] && !(BYP && (hit0 || hit1));
    end
  end
  if (READ_LAT != 0) begin : g_reg
    logic [1:0][WIDTH-1:0] rd_q;
    logic [1:0]            rb_q;
    always_ff @(posedge clk) begin
      rd_q <= rst ? '0 : rd_d;
      rb_q <= rst ? '0 : rb_d;
    end
    assign rd_o = rd_q;
    assign rb_o = rb_q;
  end else begin : g_comb
    assign rd_o = rd_d;
    assign rb_o = rb_d;
  end
  assign rdA_dat  = rd_o[0];
  assign rdB_dat  = rd_o[1];
  assign rdA_busy = rb_o[0];
  assign rdB_busy = rb_o[1];
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: checks a default instance and a registered/no-bypass/zero-r0 instance against a model
module tb_reg_file_mp;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, rda_en, rdb_en, wr0_en, wr1_en, bs_en;
  logic [2:0] rda_idx, rdb_idx, wr0_idx, wr1_idx, bs_idx;
  logic [15:0] wr0_dat, wr1_dat;
  logic [15:0] d0_rda, d0_rdb, d1_rda, d1_rdb;
  logic d0_rda_b, d0_rdb_b, d1_rda_b, d1_rdb_b;
  logic [7:0] d0_bv, d1_bv;
  int n_chk = 0, n_fail = 0;
  bit go = 0;

  reg_file_mp u_d0 (
    .clk(clk), .rst(rst),
    .rdA_en(rda_en), .rdA_idx(rda_idx), .rdA_dat(d0_rda), .rdA_busy(d0_rda_b),
    .rdB_en(rdb_en), .rdB_idx(rdb_idx), .rdB_dat(d0_rdb), .rdB_busy(d0_rdb_b),
    .wr0_en(wr0_en), .wr0_idx(wr0_idx), .wr0_dat(wr0_dat),
    .wr1_en(wr1_en), .wr1_idx(wr1_idx), .wr1_dat(wr1_dat),
    .bs_en(bs_en), .bs_idx(bs_idx), .busy_vec(d0_bv)
  );
  reg_file_mp #(.READ_LAT(1), .BYPASS(0), .ZERO_R0(1)) u_d1 (
    .clk(clk), .rst(rst),
    .rdA_en(rda_en), .rdA_idx(rda_idx), .rdA_dat(d1_rda), .rdA_busy(d1_rda_b),
    .rdB_en(rdb_en), .rdB_idx(rdb_idx), .rdB_dat(d1_rdb), .rdB_busy(d1_rdb_b),
    .wr0_en(wr0_en), .wr0_idx(wr0_idx), .wr0_dat(wr0_dat),
    .wr1_en(wr1_en), .wr1_idx(wr1_idx), .wr1_dat(wr1_dat),
    .bs_en(bs_en), .bs_idx(bs_idx), .busy_vec(d1_bv)
  );

  // model: config 0 = bypass, comb read; config 1 = no bypass, registered read, r0 hardwired
  logic [15:0] mem [2][8];
  bit busy [2][8];
  logic [15:0] e1_rda, e1_rdb;
  bit e1_rda_b, e1_rdb_b;

  function automatic logic [15:0] model_rd(int c, logic en, logic [2:0] idx);
    if (!en || (c == 1 && idx == 0)) return 16'h0;
    if (c == 0 && wr1_en && wr1_idx == idx) return wr1_dat;
    if (c == 0 && wr0_en && wr0_idx == idx) return wr0_dat;
    return mem[c][idx];
  endfunction
  function automatic bit model_busy(int c, logic [2:0] idx);
    return busy[c][idx] && !(c == 0 && ((wr0_en && wr0_idx == idx) || (wr1_en && wr1_idx == idx)));
  endfunction
  function automatic logic [7:0] model_bv(int c);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = busy[c][k];
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) for (int k = 0; k < 8; k++) begin mem[c][k] = 0; busy[c][k] = 0; end
      e1_rda = 0; e1_rdb = 0; e1_rda_b = 0; e1_rdb_b = 0;
    end else begin
      e1_rda = model_rd(1, rda_en, rda_idx); e1_rda_b = model_busy(1, rda_idx);
      e1_rdb = model_rd(1, rdb_en, rdb_idx); e1_rdb_b = model_busy(1, rdb_idx);
      for (int c = 0; c < 2; c++) begin
        if (wr0_en && !(c == 1 && wr0_idx == 0)) begin mem[c][wr0_idx] = wr0_dat; busy[c][wr0_idx] = 0; end
        if (wr1_en && !(c == 1 && wr1_idx == 0)) begin mem[c][wr1_idx] = wr1_dat; busy[c][wr1_idx] = 0; end
        if (bs_en && !(c == 1 && bs_idx == 0)) busy[c][bs_idx] = 1;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) if (go) begin
    chk("d0_rda", d0_rda, model_rd(0, rda_en, rda_idx));
    chk("d0_rdb", d0_rdb, model_rd(0, rdb_en, rdb_idx));
    chk("d0_rda_busy", d0_rda_b, model_busy(0, rda_idx));
    chk("d0_rdb_busy", d0_rdb_b, model_busy(0, rdb_idx));
    chk("d0_busy_vec", d0_bv, model_bv(0));
    chk("d1_rda", d1_rda, e1_rda);
    chk("d1_rdb", d1_rdb, e1_rdb);
    chk("d1_rda_busy", d1_rda_b, e1_rda_b);
    chk("d1_rdb_busy", d1_rdb_b, e1_rdb_b);
    chk("d1_busy_vec", d1_bv, model_bv(1));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    rst = 0; rda_en = 0; rdb_en = 0; wr0_en = 0; wr1_en = 0; bs_en = 0;
    rda_idx = 0; rdb_idx = 0; wr0_idx = 0; wr1_idx = 0; bs_idx = 0; wr0_dat = 0; wr1_dat = 0;
  endtask

  initial begin
    idle(); rst = 1; tick; tick; go = 1;
    // reset clears a written, busy register
    idle(); wr0_en = 1; wr0_idx = 3; wr0_dat = 16'hBEEF; bs_en = 1; bs_idx = 3; tick;
    idle(); #1 chk("t1_busy_before", d0_bv, 8'h08);
    rst = 1; tick;
    idle(); rda_en = 1; rda_idx = 3; #1 chk("t1_r3", d0_rda, 16'h0); chk("t1_bv", d0_bv, 8'h00);
    // write then read, latency of the registered port
    idle(); wr0_en = 1; wr0_idx = 5; wr0_dat = 16'h1234; wr1_en = 1; wr1_idx = 6; wr1_dat = 16'h0066; tick;
    idle(); rda_en = 1; rda_idx = 5; #1 chk("t2_rd5", d0_rda, 16'h1234); tick;
    idle(); rda_en = 1; rda_idx = 6; #1 chk("t5_lat1", d1_rda, 16'h1234); chk("t2_rd6", d0_rda, 16'h0066); tick;
    idle(); #1 chk("t2_disabled", d0_rda, 16'h0); chk("t5_idx_change", d1_rda, 16'h0066); tick;
    #1 chk("t5_hold0", d1_rda, 16'h0);
    // write priority and bypass
    idle(); wr0_en = 1; wr0_idx = 2; wr0_dat = 16'h1111; tick;
    idle(); wr0_en = 1; wr0_idx = 2; wr0_dat = 16'hAAAA; wr1_en = 1; wr1_idx = 2; wr1_dat = 16'h5555;
    rdb_en = 1; rdb_idx = 2; #1 chk("t3_bypass", d0_rdb, 16'h5555); tick;
    idle(); rdb_en = 1; rdb_idx = 2; #1 chk("t3_nobypass_old", d1_rdb, 16'h1111); chk("t3_stored", d0_rdb, 16'h5555); tick;
    #1 chk("t3_stored_d1", d1_rdb, 16'h5555);
    // scoreboard
    idle(); bs_en = 1; bs_idx = 4; tick;
    idle(); rda_en = 1; rda_idx = 4; #1 chk("t4_bv", d0_bv, 8'h10); chk("t4_rda_busy", d0_rda_b, 1'b1);
    bs_en = 1; bs_idx = 4; wr0_en = 1; wr0_idx = 4; wr0_dat = 16'h0044; tick;
    idle(); rda_en = 1; rda_idx = 4; #1 chk("t4_set_wins", d0_bv, 8'h10);
    wr1_en = 1; wr1_idx = 4; wr1_dat = 16'h4444; #1 chk("t4_busy_bypassed", d0_rda_b, 1'b0); tick;
    idle(); #1 chk("t4_cleared", d0_bv, 8'h00); chk("t4_d1_cleared", d1_bv, 8'h00);
    // hardwired r0 on the second instance
    wr0_en = 1; wr0_idx = 0; wr0_dat = 16'hFFFF; bs_en = 1; bs_idx = 0; tick;
    idle(); rda_en = 1; rda_idx = 0; #1 chk("t6_bv0", d1_bv[0], 1'b0); chk("t6_d0_r0", d0_rda, 16'hFFFF); tick;
    #1 chk("t6_r0", d1_rda, 16'h0);
    // randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(63) == 0;
      rda_en = $urandom_range(1); rdb_en = $urandom_range(1);
      wr0_en = $urandom_range(1); wr1_en = $urandom_range(1); bs_en = $urandom_range(2) == 0;
      rda_idx = 3'($urandom); rdb_idx = 3'($urandom); wr0_idx = 3'($urandom);
      wr1_idx = 3'($urandom); bs_idx = 3'($urandom);
      wr0_dat = 16'($urandom); wr1_dat = 16'($urandom);
      tick;
    end
    idle(); tick; tick;
    go = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
